// File: rtl/vita_midi_pkg.sv
// Shared MIDI constants and message decoding for the voice allocator slice.
// The optional sustain pedal is built only when SUSTAIN_PEDAL_EN is defined.
package vita_midi_pkg;

  localparam logic [3:0] NOTE_OFF         = 4'h8;
  localparam logic [3:0] NOTE_ON          = 4'h9;
  localparam logic [3:0] CTRL_CHANGE      = 4'hB;
  localparam logic [6:0] CC_SUSTAIN       = 7'd64;
  localparam logic [6:0] CC_ALL_NOTES_OFF = 7'd123;

  localparam int         AGE_W   = 3;
  localparam logic [2:0] AGE_MAX = 3'd7;

  typedef enum logic [2:0] {
    ACT_NONE,
    ACT_NOTE_ON,
    ACT_NOTE_OFF,
    ACT_ALL_OFF,
    ACT_SUS_ON,
    ACT_SUS_OFF
  } msg_act_e;

  // A note-on with zero velocity is a note-off; the pedal is "down" at value 64 and above.
  function automatic msg_act_e decode_msg(input logic [3:0] cm, input logic [6:0] num,
                                          input logic [6:0] val);
    msg_act_e act;
    act = ACT_NONE;
    case (cm)
      NOTE_ON:     act = (val != 7'd0) ? ACT_NOTE_ON : ACT_NOTE_OFF;
      NOTE_OFF:    act = ACT_NOTE_OFF;
      CTRL_CHANGE: begin
        if (num == CC_ALL_NOTES_OFF) begin
          act = ACT_ALL_OFF;
        end else if (num == CC_SUSTAIN) begin
          act = val[6] ? ACT_SUS_ON : ACT_SUS_OFF;
        end else begin
          act = ACT_NONE;
        end
      end
      default:     act = ACT_NONE;
    endcase
    return act;
  endfunction

endpackage

// File: rtl/midi_voice_alloc_voice_pick.sv
// Combinational voice search: lowest-index free voice and oldest voice
// (ties resolve to the lowest index).
module voice_pick
  import vita_midi_pkg::*;
#(
  parameter int VOICES = 4
) (
  input  logic [VOICES-1:0]       gate,
  input  logic [AGE_W*VOICES-1:0] ages,
  output logic [2:0]              free_idx,
  output logic                    free_valid,
  output logic [2:0]              oldest_idx
);

  logic [AGE_W-1:0] best_age_s;
  logic             older_s;

  // Descending scan leaves the lowest free index; strict compare keeps ties on the lower index
  always_comb begin
    free_idx   = 3'd0;
    free_valid = 1'b0;
    oldest_idx = 3'd0;
    best_age_s = ages[AGE_W-1:0];
    older_s    = 1'b0;
    for (int i = VOICES - 1; i >= 0; i--) begin
      free_idx   = gate[i] ? free_idx : 3'(i);
      free_valid = free_valid | ~gate[i];
    end
    for (int i = 1; i < VOICES; i++) begin
      older_s    = ages[AGE_W*i +: AGE_W] > best_age_s;
      oldest_idx = older_s ? 3'(i) : oldest_idx;
      best_age_s = older_s ? ages[AGE_W*i +: AGE_W] : best_age_s;
    end
  end

endmodule

// File: rtl/midi_voice_alloc.sv
// Polyphonic MIDI voice allocator with retrigger, oldest-voice stealing and all-notes-off.
// Optional sustain pedal (CC64) is enabled by defining SUSTAIN_PEDAL_EN.
module midi_voice_alloc
  import vita_midi_pkg::*;
#(
  parameter int         VOICES    = 4,
  parameter logic [3:0] DRUM_CHAN = 4'd9
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  msg_stb,
  input  logic [3:0]            ch_message,
  input  logic [3:0]            chan,
  input  logic [6:0]            note,
  input  logic [6:0]            velocity,
  output logic [VOICES-1:0]     gate,
  output logic [VOICES-1:0]     trig,
  output logic [7*VOICES-1:0]   voice_note,
  output logic [7*VOICES-1:0]   voice_vel,
  output logic                  steal
);

  logic [VOICES-1:0]       gate_r, trig_r, gate_s, trig_s, match_s, busy_s;
  logic [7*VOICES-1:0]     note_r, vel_r, note_s, vel_s;
  logic [AGE_W*VOICES-1:0] ages_r, ages_s;
  logic                    steal_r, steal_s, hit_s, free_valid_s;
  logic [2:0]              hit_idx_s, tgt_idx_s, free_idx_s, oldest_idx_s;
  msg_act_e                act_s;
`ifdef SUSTAIN_PEDAL_EN
  logic [VOICES-1:0]       held_r, held_s;
  logic                    pedal_r, pedal_s;

  assign busy_s = gate_r | held_r;
`else
  assign busy_s = gate_r;
`endif

  voice_pick #(.VOICES(VOICES)) u_pick (
    .gate       (busy_s),
    .ages       (ages_r),
    .free_idx   (free_idx_s),
    .free_valid (free_valid_s),
    .oldest_idx (oldest_idx_s)
  );

  // Decode the message and choose the target voice: sounding match, else free, else oldest
  always_comb begin
    act_s     = (msg_stb && (chan != DRUM_CHAN)) ? decode_msg(ch_message, note, velocity) : ACT_NONE;
    match_s   = '0;
    hit_s     = 1'b0;
    hit_idx_s = 3'd0;
    for (int i = VOICES - 1; i >= 0; i--) begin
      match_s[i] = gate_r[i] && (note_r[7*i +: 7] == note);
      hit_idx_s  = match_s[i] ? 3'(i) : hit_idx_s;
      hit_s      = hit_s | match_s[i];
    end
    tgt_idx_s = hit_s ? hit_idx_s : (free_valid_s ? free_idx_s : oldest_idx_s);
  end

  // Next-state of every voice; trig and steal default low so they pulse for one cycle
  always_comb begin
    gate_s  = gate_r;
    trig_s  = '0;
    steal_s = 1'b0;
    note_s  = note_r;
    vel_s   = vel_r;
    ages_s  = ages_r;
`ifdef SUSTAIN_PEDAL_EN
    held_s  = held_r;
    pedal_s = pedal_r;
`endif
    case (act_s)
      ACT_NOTE_ON: begin
        steal_s = ~hit_s & ~free_valid_s;
        for (int i = 0; i < VOICES; i++) begin
          if (3'(i) == tgt_idx_s) begin
            note_s[7*i +: 7]         = note;
            vel_s[7*i +: 7]          = velocity;
            gate_s[i]                = 1'b1;
            trig_s[i]                = 1'b1;
            ages_s[AGE_W*i +: AGE_W] = 3'd0;
`ifdef SUSTAIN_PEDAL_EN
            held_s[i]                = 1'b0;
`endif
          end else if (ages_r[AGE_W*i +: AGE_W] != AGE_MAX) begin
            ages_s[AGE_W*i +: AGE_W] = ages_r[AGE_W*i +: AGE_W] + 3'd1;
          end else begin
            ages_s[AGE_W*i +: AGE_W] = AGE_MAX;
          end
        end
      end
      ACT_NOTE_OFF: begin
        for (int i = 0; i < VOICES; i++) begin
          if (match_s[i]) begin
`ifdef SUSTAIN_PEDAL_EN
            if (pedal_r) begin
              held_s[i] = 1'b1;
            end else begin
              gate_s[i] = 1'b0;
            end
`else
            gate_s[i] = 1'b0;
`endif
          end else begin
            gate_s[i] = gate_r[i];
          end
        end
      end
      ACT_ALL_OFF: begin
        gate_s = '0;
`ifdef SUSTAIN_PEDAL_EN
        held_s = '0;
`endif
      end
`ifdef SUSTAIN_PEDAL_EN
      ACT_SUS_ON:  pedal_s = 1'b1;
      ACT_SUS_OFF: begin
        pedal_s = 1'b0;
        gate_s  = gate_r & ~held_r;
        held_s  = '0;
      end
`endif
      default: begin
        gate_s = gate_r;
      end
    endcase
  end

  // State register; reset leaves voice i with age i so voice 0 is the youngest
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gate_r  <= '0;
      trig_r  <= '0;
      steal_r <= 1'b0;
      note_r  <= '0;
      vel_r   <= '0;
      for (int i = 0; i < VOICES; i++) begin
        ages_r[AGE_W*i +: AGE_W] <= 3'(i);
      end
`ifdef SUSTAIN_PEDAL_EN
      held_r  <= '0;
      pedal_r <= 1'b0;
`endif
    end else begin
      gate_r  <= gate_s;
      trig_r  <= trig_s;
      steal_r <= steal_s;
      note_r  <= note_s;
      vel_r   <= vel_s;
      ages_r  <= ages_s;
`ifdef SUSTAIN_PEDAL_EN
      held_r  <= held_s;
      pedal_r <= pedal_s;
`endif
    end
  end

  assign gate       = gate_r;
  assign trig       = trig_r;
  assign steal      = steal_r;
  assign voice_note = note_r;
  assign voice_vel  = vel_r;

endmodule
